// File: rtl/alarm_ring.sv
// Alarm minute-match ringer: beeps the buzzer for a bounded time after the
// current minute matches the stored alarm minute, with stop and limited snooze.
module alarm_ring #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min2,
    input  logic [3:0] alarm_min1,
    input  logic [3:0] alarm_min2,
    input  logic       stop,
    input  logic       snooze,
    output logic       buzz,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_left
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] RING_END   = 8'(RING_SECS);
    localparam logic [9:0] SNOOZE_END = 10'(SNOOZE_SECS);
    localparam logic [2:0] SNOOZE_MAX = 3'(MAX_SNOOZE);

    state_t     state, state_nx;
    logic [7:0] ring_cnt, ring_cnt_nx;
    logic [9:0] snz_cnt, snz_cnt_nx;
    logic       buzz_nx;
    logic [2:0] left_nx;
    logic       match;

    assign match = (cur_min1 == alarm_min1) && (cur_min2 == alarm_min2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            buzz        <= 1'b0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            snooze_left <= SNOOZE_MAX;
        end else begin
            state       <= state_nx;
            ring_cnt    <= ring_cnt_nx;
            snz_cnt     <= snz_cnt_nx;
            buzz        <= buzz_nx;
            ringing     <= (state_nx == RING);
            snoozing    <= (state_nx == SNOOZE);
            snooze_left <= left_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        ring_cnt_nx = ring_cnt;
        snz_cnt_nx  = snz_cnt;
        buzz_nx     = buzz;
        left_nx     = snooze_left;

        if (!alarm_en) begin
            state_nx = IDLE;
            buzz_nx  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    buzz_nx = 1'b0;
                    if (match) begin
                        state_nx    = RING;
                        ring_cnt_nx = '0;
                        buzz_nx     = 1'b1;
                        left_nx     = SNOOZE_MAX;
                    end
                end
                RING: begin
                    // Button presses take priority over a coincident tick.
                    if (stop) begin
                        state_nx = DONE;
                        buzz_nx  = 1'b0;
                    end else if (snooze) begin
                        buzz_nx = 1'b0;
                        if (snooze_left != 3'd0) begin
                            state_nx   = SNOOZE;
                            left_nx    = snooze_left - 3'd1;
                            snz_cnt_nx = '0;
                        end else begin
                            state_nx = DONE;
                        end
                    end else if (tick_1hz) begin
                        ring_cnt_nx = ring_cnt + 8'd1;
                        buzz_nx     = ~buzz;
                        if (ring_cnt + 8'd1 == RING_END) begin
                            state_nx = DONE;
                            buzz_nx  = 1'b0;
                        end
                    end
                end
                SNOOZE: begin
                    buzz_nx = 1'b0;
                    if (stop) begin
                        state_nx = DONE;
                    end else if (tick_1hz) begin
                        snz_cnt_nx = snz_cnt + 10'd1;
                        if (snz_cnt + 10'd1 == SNOOZE_END) begin
                            state_nx    = RING;
                            ring_cnt_nx = '0;
                            buzz_nx     = 1'b1;
                        end
                    end
                end
                DONE: begin
                    buzz_nx = 1'b0;
                    if (!match) state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    buzz_nx  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ring.sv
// Directed bench for alarm_ring with a short snooze interval.
module tb_alarm_ring;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, alarm_en, stop, snooze;
    logic [3:0] cur_min1, cur_min2, alarm_min1, alarm_min2;
    logic       buzz, ringing, snoozing;
    logic [2:0] snooze_left;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_ring #(.RING_SECS(60), .SNOOZE_SECS(4), .MAX_SNOOZE(3)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .alarm_en(alarm_en),
        .cur_min1(cur_min1), .cur_min2(cur_min2),
        .alarm_min1(alarm_min1), .alarm_min2(alarm_min2),
        .stop(stop), .snooze(snooze),
        .buzz(buzz), .ringing(ringing), .snoozing(snoozing),
        .snooze_left(snooze_left)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int b, input int r, input int s, input int l);
        chk({tag, ".buzz"}, int'(buzz), b);
        chk({tag, ".ringing"}, int'(ringing), r);
        chk({tag, ".snoozing"}, int'(snoozing), s);
        chk({tag, ".left"}, int'(snooze_left), l);
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0; stop = 1'b0; snooze = 1'b0;
        cur_min1 = 4'd0; cur_min2 = 4'd0; alarm_min1 = 4'd0; alarm_min2 = 4'd7;
        step();
        rst = 1'b0;
        chk_out("reset", 0, 0, 0, 3);

        // Basic ring and timeout
        alarm_en = 1'b1; cur_min2 = 4'd6;
        step();
        chk("pre_match.ringing", int'(ringing), 0);
        cur_min2 = 4'd7;
        step();
        chk_out("match", 1, 1, 0, 3);
        tick(1);
        chk("tick1.buzz", int'(buzz), 0);
        tick(1);
        chk("tick2.buzz", int'(buzz), 1);
        tick(57);
        chk_out("tick59", 0, 1, 0, 3);
        tick(1);
        chk_out("tick60", 0, 0, 0, 3);
        step(); step(); step();
        chk("done_hold.ringing", int'(ringing), 0);
        cur_min2 = 4'd8;
        step();
        chk("to_idle.ringing", int'(ringing), 0);
        cur_min2 = 4'd7;
        step();
        chk("retrigger.ringing", int'(ringing), 1);

        // Stop wins over snooze
        tick(5);
        chk("stop_pre.buzz", int'(buzz), 0);
        stop = 1'b1; snooze = 1'b1;
        step();
        stop = 1'b0; snooze = 1'b0;
        chk_out("stop_prio", 0, 0, 0, 3);
        cur_min2 = 4'd8; step();
        cur_min2 = 4'd7; step();
        chk_out("ring2", 1, 1, 0, 3);

        // Snooze cycle; snooze press inside SNOOZE is ignored
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_out("snz1", 0, 0, 1, 2);
        tick(1);
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_out("snz_ignore", 0, 0, 1, 2);
        tick(2);
        chk("snz_t3.snoozing", int'(snoozing), 1);
        tick(1);
        chk_out("snz1_expire", 1, 1, 0, 2);

        // Exhaustion; second press coincides with a tick
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_out("snz2", 0, 0, 1, 1);
        tick(4);
        chk_out("snz2_expire", 1, 1, 0, 1);
        snooze = 1'b1; tick_1hz = 1'b1; step(); snooze = 1'b0; tick_1hz = 1'b0;
        chk_out("snz3", 0, 0, 1, 0);
        tick(4);
        chk_out("snz3_expire", 1, 1, 0, 0);
        snooze = 1'b1; step(); snooze = 1'b0;
        chk_out("snz4_done", 0, 0, 0, 0);
        step();
        chk("snz4_hold.ringing", int'(ringing), 0);

        // Disable mid-snooze, then re-enable within the matching minute
        cur_min2 = 4'd8; step();
        cur_min2 = 4'd7; step();
        chk_out("ring3", 1, 1, 0, 3);
        snooze = 1'b1; step(); snooze = 1'b0;
        chk("ring3_snz.snoozing", int'(snoozing), 1);
        alarm_en = 1'b0; step();
        chk("dis.buzz", int'(buzz), 0);
        chk("dis.ringing", int'(ringing), 0);
        chk("dis.snoozing", int'(snoozing), 0);
        alarm_en = 1'b1; step();
        chk_out("reen", 1, 1, 0, 3);

        // Reset in RING after a snooze round trip
        snooze = 1'b1; step(); snooze = 1'b0;
        tick(4);
        chk_out("pre_rst", 1, 1, 0, 2);
        rst = 1'b1; step(); rst = 1'b0;
        cur_min2 = 4'd8;
        chk_out("rst_ring", 0, 0, 0, 3);
        step();
        chk("post_rst.ringing", int'(ringing), 0);

        // BCD rollover edge: 58 -> 59 -> 00
        alarm_min1 = 4'd5; alarm_min2 = 4'd9;
        cur_min1 = 4'd5; cur_min2 = 4'd8;
        step();
        chk("m58.ringing", int'(ringing), 0);
        cur_min2 = 4'd9;
        step();
        chk_out("m59", 1, 1, 0, 3);
        tick(60);
        chk_out("m59_timeout", 0, 0, 0, 3);
        cur_min1 = 4'd0; cur_min2 = 4'd0;
        step();
        chk("m00.ringing", int'(ringing), 0);
        cur_min1 = 4'd5; cur_min2 = 4'd9;
        step();
        chk("m59_again.ringing", int'(ringing), 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("m59_stop.ringing", int'(ringing), 0);

        // Digit order: alarm 10 must not match cur 01
        alarm_min1 = 4'd1; alarm_min2 = 4'd0;
        cur_min1 = 4'd0; cur_min2 = 4'd1;
        step(); step(); step();
        chk_out("swap", 0, 0, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
